// File: rtl/param_tx_frame_sequencer.sv
// param_tx_frame_sequencer
//
// Owns the read-only second port of the parameter TX RAM. A start command
// reads a contiguous run of words and streams them out as one frame with
// SOP on the first data word, followed by a 32-bit additive checksum word
// carrying EOP.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle command pulse (ignored while busy)
//   base_addr           first word address, sampled on start
//   word_count          number of data words, sampled on start
//   abort               cancel the current frame (no effect when idle)
//   busy                high from the accepted start until done/abort
//   done                one-cycle pulse after the checksum word transfers
//   err_len             one-cycle pulse after a rejected start
//   ram_address         port-2 word address
//   ram_chipselect      port-2 read strobe
//   ram_write           tied low; this port only reads
//   ram_readdata        port-2 data, valid the cycle after the strobe
//   src_data/valid/ready/sop/eop   outgoing stream
//
// Stream handshake: a word transfers in every cycle where src_valid and
// src_ready are both high; while src_valid is high and src_ready is low,
// src_data, src_sop and src_eop hold their values.

module param_tx_frame_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1025
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_CSUM  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              active;
  logic              kill;
  logic              data_valid;
  logic              data_xfer;
  logic              rd_issue;
  logic              len_bad;
  logic [2:0]        budget;
  logic [ADDR_W:0]   end_addr;
  logic [DATA_W-1:0] fifo_head;

  assign active     = (state_q != S_IDLE);
  assign kill       = active & abort;
  assign fifo_head  = fifo_q[rd_ptr_q];
  assign data_valid = ((state_q == S_READ) || (state_q == S_DRAIN)) && (cnt_q != 2'd0);
  assign data_xfer  = data_valid & src_ready;

  // Words buffered plus words in flight, after this cycle's transfer. A new
  // read is allowed only if its data is guaranteed a FIFO slot on arrival.
  // No read is issued during an abort since its data would be discarded.
  assign budget   = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, data_xfer};
  assign rd_issue = (state_q == S_READ) && (budget < 3'd2) && !abort;

  // Evaluated one bit wider than the address so base+count cannot wrap.
  assign end_addr = {1'b0, base_addr} + {1'b0, word_count};
  assign len_bad  = (word_count == '0) || (end_addr > DEPTH_L);

  // FIFO occupancy: write when the previous cycle's read data lands.
  always_comb begin
    cnt_d = cnt_q;
    case ({rd_pend_q, data_xfer})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (kill) begin
      cnt_d = 2'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    left_d    = left_q;
    rd_pend_d = rd_issue;
    first_d   = first_q;
    csum_d    = csum_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (data_xfer) begin
      csum_d  = csum_q + fifo_head;
      first_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_READ;
            rd_addr_d = base_addr;
            left_d    = word_count;
            csum_d    = '0;
            first_d   = 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          left_d    = left_q - ADDR_W'(1);
          if (left_q == ADDR_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last in-flight word (if any) is counted in cnt_d, so an empty
        // cnt_d means every data word has left the block.
        if (cnt_d == 2'd0) begin
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (src_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d   = S_IDLE;
      rd_pend_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      left_q    <= '0;
      rd_pend_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      first_q   <= 1'b0;
      csum_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      left_q    <= left_d;
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      csum_q    <= csum_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (kill) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (rd_pend_q) begin
          fifo_q[wr_ptr_q] <= ram_readdata;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (data_xfer) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign busy           = active;
  assign done           = done_q;
  assign err_len        = err_q;
  assign ram_write      = 1'b0;
  assign ram_chipselect = rd_issue;
  assign ram_address    = rd_issue ? rd_addr_q : '0;
  assign src_valid      = data_valid || (state_q == S_CSUM);
  assign src_data       = (state_q == S_CSUM) ? csum_q : (data_valid ? fifo_head : '0);
  assign src_sop        = data_valid & first_q;
  assign src_eop        = (state_q == S_CSUM);

endmodule

// File: doc/param_tx_frame_sequencer.md
Name: param_tx_frame_sequencer

Overview:
- Owns the second port of the parameter TX RAM (1025 x 32-bit dual-port). Software fills parameter words through port 1.
- On a start command, reads a contiguous run of words through port 2 and streams them out as one frame with SOP/EOP marking, followed by a 32-bit additive checksum word.
- Feeds the downstream parameter serializer over a valid/ready interface and reports busy/done/error to the control register block.

Parameters:
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, RAM and stream data width.
- DEPTH, 1025, number of valid RAM words; addresses 0..DEPTH-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse
- base_addr  in  ADDR_W  first word address, sampled on start
- word_count  in  ADDR_W  number of data words, sampled on start
- abort  in  1  cancel the current frame
- busy  out  1  high from the accepted start until done, abort or error
- done  out  1  one-cycle pulse when the checksum word is accepted
- err_len  out  1  one-cycle pulse when a start is rejected
- ram_address  out  ADDR_W  port-2 address
- ram_chipselect  out  1  port-2 read strobe
- ram_write  out  1  constant 0; this port is read-only
- ram_readdata  in  DATA_W  port-2 data, valid the cycle after the strobe
- src_data  out  DATA_W  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready; a transfer occurs when valid and ready are both high
- src_sop  out  1  high with the first data word
- src_eop  out  1  high with the checksum word

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, checksum 0.
- States:
  - IDLE: waits for start.
  - READ: issues RAM reads.
  - DRAIN: all reads issued; emptying the buffer.
  - CSUM: presents the checksum word.
- start in IDLE:
  - Rejected if word_count==0 or base_addr+word_count > DEPTH. The sum is computed at ADDR_W+1 bits, so there is no wrap-around.
  - On rejection: err_len pulses next cycle, state stays IDLE, busy stays 0.
  - Otherwise: latch base and count, clear the checksum, busy=1 next cycle, go to READ.
  - start while busy is ignored.
- Read timing: ram_chipselect=1 with ram_address=A in cycle N makes ram_readdata=mem[A] valid in cycle N+1. Captured data goes into a 2-entry FIFO.
- Read issue rule: a read is issued in cycle N only if (FIFO occupancy + reads in flight − transfer this cycle) < 2. Reads go in ascending address order. After the last read (count reached), go to DRAIN.
- src_valid is high whenever the FIFO is non-empty and src_data is the FIFO head. With src_ready held high the stream runs at 1 word/cycle with no bubbles.
- src_sop=1 only on the first data word of the frame, held until that word transfers.
- Checksum: sum modulo 2^32 of all data words, updated on each data transfer.
- CSUM state is entered when DRAIN has an empty FIFO. It drives src_valid=1, src_data=checksum, src_eop=1 and holds them stable until src_ready. The transfer returns to IDLE with a done pulse on the next cycle and busy=0.
- Latency:
  - start in cycle 0 → first ram_chipselect in cycle 1 → first src_valid in cycle 3.
  - Frame of n words with continuous ready: checksum transfers in cycle n+3; done in cycle n+4.
- Backpressure: src_data, src_sop and src_eop stay stable while src_valid=1 and src_ready=0. No read is issued that would overflow the FIFO.
- abort (any non-IDLE state) takes effect on the next cycle:
  - state IDLE, FIFO flushed, in-flight data discarded;
  - src_valid=0, busy=0;
  - no done pulse and no EOP.
  - abort in IDLE has no effect. If abort and start arrive in the same cycle, abort wins.
- Asynchronous reset mid-frame: the frame is dropped immediately and all outputs return to their reset values.
- Addresses and words are never reordered, skipped or duplicated.

Test Plan:
- RAM[10..13]={1,2,3,0xFFFFFFFF}; start base=10 count=4 with ready=1 → src_data 1,2,3,0xFFFFFFFF,0x00000005. SOP on word 1, EOP on the checksum. First valid in cycle 3, done in cycle 8.
- Same frame with src_ready toggling 1,0,0,1 repeatedly → identical data sequence; data held stable while stalled; ram_chipselect never leaves more than 2 words buffered or in flight.
- base=1020, count=5 → accepted; reads addresses 1020..1024. base=1021, count=5 → err_len pulse, busy stays 0, no chipselect. count=0 → err_len.
- count=1, base=0, RAM[0]=0xA5A5A5A5 → two words, both equal to 0xA5A5A5A5; SOP on the first, EOP on the second.
- abort asserted while the third of 8 words is stalled → next cycle busy=0 and src_valid=0, no done. A new start base=0 count=2 then produces a clean frame with the checksum recomputed from 0.
- start pulsed again while busy → ignored, frame unchanged. Asynchronous reset mid-stream → all outputs 0 immediately.
